// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts FFT frames in bit-reversed order and
// replays them in natural bin order with index and frame markers.
module fft_bitrev_reorder #(
    parameter int unsigned N     = 64,
    parameter int unsigned LOG2N = 6,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             data_in_en,
    input  logic [WIDTH-1:0] data_in_real,
    input  logic [WIDTH-1:0] data_in_imag,
    output logic             data_out_en,
    output logic [WIDTH-1:0] data_out_real,
    output logic [WIDTH-1:0] data_out_imag,
    output logic [LOG2N-1:0] data_out_idx,
    output logic             data_out_sof,
    output logic             data_out_eof
);

    localparam int unsigned DEPTH = 2 * N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    logic [WIDTH-1:0] mem_real [DEPTH];
    logic [WIDTH-1:0] mem_imag [DEPTH];

    logic [LOG2N-1:0] wr_cnt;
    logic             wr_bank;
    logic             wr_last;
    logic [1:0]       full;
    logic [1:0]       full_next;

    state_t           state;
    state_t           state_next;
    logic             rd_bank;
    logic             rd_bank_next;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] rd_cnt_next;
    logic             rd_issue;
    logic             rd_done;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    assign wr_last = data_in_en && (wr_cnt == LAST);

    // Sample storage; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (reset && data_in_en) begin
            mem_real[{wr_bank, bitrev(wr_cnt)}] <= data_in_real;
            mem_imag[{wr_bank, bitrev(wr_cnt)}] <= data_in_imag;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (data_in_en) begin
            wr_cnt <= wr_cnt + LOG2N'(1);
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Reader clear and writer set can land on the same edge (different banks).
    always_comb begin
        full_next = full;
        if (rd_done) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            state   <= state_next;
            rd_bank <= rd_bank_next;
            rd_cnt  <= rd_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        rd_bank_next = rd_bank;
        rd_cnt_next  = rd_cnt;
        rd_issue     = 1'b0;
        rd_done      = 1'b0;
        case (state)
            IDLE: begin
                if (full[0]) begin
                    state_next   = READ;
                    rd_bank_next = 1'b0;
                    rd_cnt_next  = '0;
                end else if (full[1]) begin
                    state_next   = READ;
                    rd_bank_next = 1'b1;
                    rd_cnt_next  = '0;
                end
            end
            READ: begin
                rd_issue    = 1'b1;
                rd_cnt_next = rd_cnt + LOG2N'(1);
                if (rd_cnt == LAST) begin
                    rd_done = 1'b1;
                    // Chain straight into the other bank when it is ready.
                    if (full[~rd_bank]) begin
                        rd_bank_next = ~rd_bank;
                        rd_cnt_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || !rd_issue) begin
            data_out_en   <= 1'b0;
            data_out_real <= '0;
            data_out_imag <= '0;
            data_out_idx  <= '0;
            data_out_sof  <= 1'b0;
            data_out_eof  <= 1'b0;
        end else begin
            data_out_en   <= 1'b1;
            data_out_real <= mem_real[{rd_bank, rd_cnt}];
            data_out_imag <= mem_imag[{rd_bank, rd_cnt}];
            data_out_idx  <= rd_cnt;
            data_out_sof  <= (rd_cnt == '0);
            data_out_eof  <= (rd_cnt == LAST);
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at N=64, plus N=16 and N=4 instances.
module tb_fft_bitrev_reorder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        in_en;
    logic [15:0] in_real, in_imag;
    logic        out_en, out_sof, out_eof;
    logic [15:0] out_real, out_imag;
    logic [5:0]  out_idx;

    logic        s16_in_en, s16_out_en, s16_out_sof, s16_out_eof;
    logic [15:0] s16_in_real, s16_in_imag, s16_out_real, s16_out_imag;
    logic [3:0]  s16_out_idx;

    logic        s4_in_en, s4_out_en, s4_out_sof, s4_out_eof;
    logic [15:0] s4_in_real, s4_in_imag, s4_out_real, s4_out_imag;
    logic [1:0]  s4_out_idx;

    int cyc = 0;
    int cmp = 0;
    int mism = 0;

    always @(posedge clock) cyc <= cyc + 1;

    fft_bitrev_reorder #(.N(64), .LOG2N(6), .WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .data_in_en(in_en), .data_in_real(in_real), .data_in_imag(in_imag),
        .data_out_en(out_en), .data_out_real(out_real), .data_out_imag(out_imag),
        .data_out_idx(out_idx), .data_out_sof(out_sof), .data_out_eof(out_eof)
    );

    fft_bitrev_reorder #(.N(16), .LOG2N(4), .WIDTH(16)) dut16 (
        .clock(clock), .reset(reset),
        .data_in_en(s16_in_en), .data_in_real(s16_in_real), .data_in_imag(s16_in_imag),
        .data_out_en(s16_out_en), .data_out_real(s16_out_real), .data_out_imag(s16_out_imag),
        .data_out_idx(s16_out_idx), .data_out_sof(s16_out_sof), .data_out_eof(s16_out_eof)
    );

    fft_bitrev_reorder #(.N(4), .LOG2N(2), .WIDTH(16)) dut4 (
        .clock(clock), .reset(reset),
        .data_in_en(s4_in_en), .data_in_real(s4_in_real), .data_in_imag(s4_in_imag),
        .data_out_en(s4_out_en), .data_out_real(s4_out_real), .data_out_imag(s4_out_imag),
        .data_out_idx(s4_out_idx), .data_out_sof(s4_out_sof), .data_out_eof(s4_out_eof)
    );

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (v[i]) r |= (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    function automatic logic [40:0] main_out();
        return {out_en, out_idx, out_sof, out_eof, out_real, out_imag};
    endfunction

    function automatic logic [40:0] small_out(input int n);
        if (n == 16)
            return {s16_out_en, 2'b00, s16_out_idx, s16_out_sof, s16_out_eof, s16_out_real, s16_out_imag};
        return {s4_out_en, 4'b0000, s4_out_idx, s4_out_sof, s4_out_eof, s4_out_real, s4_out_imag};
    endfunction

    task automatic set_small(input int n, input logic en, input int re, input int im);
        if (n == 16) begin
            s16_in_en = en; s16_in_real = 16'(re); s16_in_imag = 16'(im);
        end else begin
            s4_in_en = en; s4_in_real = 16'(re); s4_in_imag = 16'(im);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives nframes of 64 samples and checks the reordered stream and latency.
    task automatic run_frames(input int nframes, input bit gapped, input string name);
        int first_last = -1;
        int first_out = -1;
        fork
            begin
                for (int f = 0; f < nframes; f++) begin
                    for (int p = 0; p < 64; p++) begin
                        if (gapped && p > 0) begin
                            in_en = 1'b0;
                            tick();
                        end
                        in_en   = 1'b1;
                        in_real = 16'(256 * f + bitrev(p, 6));
                        in_imag = 16'(p);
                        tick();
                        if (f == 0 && p == 63) first_last = cyc;
                    end
                end
                in_en = 1'b0;
            end
            begin
                int budget = 0;
                tick();
                while (!out_en && budget < 400) begin
                    tick();
                    budget++;
                end
                if (out_en !== 1'b1) begin
                    cmp++; mism++;
                    $display("FAIL %s start: data_out_en never rose", name);
                end else begin
                    first_out = cyc;
                    for (int i = 0; i < nframes * 64; i++) begin
                        int k = i % 64;
                        int f = i / 64;
                        logic [40:0] exp;
                        logic [40:0] got;
                        if (i > 0) tick();
                        exp = {1'b1, 6'(k), k == 0, k == 63, 16'(256 * f + k), 16'(bitrev(k, 6))};
                        got = main_out();
                        cmp++;
                        if (got !== exp) begin
                            mism++;
                            $display("FAIL %s sample %0d: got %h expected %h", name, i, got, exp);
                        end
                    end
                    tick();
                    cmp++;
                    if (out_en !== 1'b0) begin
                        mism++;
                        $display("FAIL %s tail: data_out_en=%b expected 0", name, out_en);
                    end
                end
            end
        join
        if (first_out >= 0) begin
            cmp++;
            if (first_out !== first_last + 2) begin
                mism++;
                $display("FAIL %s latency: bin0 at edge %0d expected %0d", name, first_out, first_last + 2);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_en = 1'b1;
        repeat (3) begin
            in_real = 16'($urandom);
            in_imag = 16'($urandom);
            tick();
            cmp++;
            if (main_out() !== 41'd0) begin
                mism++;
                $display("FAIL reset outputs: got %h expected 0", main_out());
            end
        end
        in_en = 1'b0;
        reset = 1'b1;
        repeat (4) begin
            tick();
            cmp++;
            if (out_en !== 1'b0) begin
                mism++;
                $display("FAIL reset no_frame: data_out_en=%b expected 0", out_en);
            end
        end
    endtask

    task automatic test_single_frame();
        run_frames(1, 1'b0, "single");
    endtask

    task automatic test_gapped();
        run_frames(1, 1'b1, "gapped");
    endtask

    task automatic test_back_to_back();
        run_frames(3, 1'b0, "b2b");
    endtask

    task automatic test_mid_frame_reset();
        int budget = 0;
        in_en = 1'b1;
        for (int p = 0; p < 30; p++) begin
            in_real = 16'hdead;
            in_imag = 16'hbeef;
            tick();
        end
        in_en = 1'b0;
        reset = 1'b0;
        tick();
        cmp++;
        if (main_out() !== 41'd0) begin
            mism++;
            $display("FAIL midreset_in outputs: got %h expected 0", main_out());
        end
        reset = 1'b1;
        repeat (3) tick();
        run_frames(1, 1'b0, "after_input_reset");

        in_en = 1'b1;
        for (int p = 0; p < 64; p++) begin
            in_real = 16'h5a5a;
            in_imag = 16'ha5a5;
            tick();
        end
        in_en = 1'b0;
        while (!out_en && budget < 20) begin
            tick();
            budget++;
        end
        cmp++;
        if (out_en !== 1'b1) begin
            mism++;
            $display("FAIL midreset_out start: data_out_en=%b expected 1", out_en);
        end
        repeat (9) tick();
        reset = 1'b0;
        tick();
        cmp++;
        if (main_out() !== 41'd0) begin
            mism++;
            $display("FAIL midreset_out stop: got %h expected 0", main_out());
        end
        reset = 1'b1;
        repeat (5) begin
            tick();
            cmp++;
            if (out_en !== 1'b0) begin
                mism++;
                $display("FAIL midreset_out stale: data_out_en=%b expected 0", out_en);
            end
        end
        run_frames(1, 1'b0, "after_output_reset");
    endtask

    task automatic run_small(input int n);
        int bits = (n == 16) ? 4 : 2;
        int last = -1;
        int first_out = -1;
        fork
            begin
                for (int p = 0; p < n; p++) begin
                    set_small(n, 1'b1, bitrev(p, bits), p);
                    tick();
                    if (p == n - 1) last = cyc;
                end
                set_small(n, 1'b0, 0, 0);
            end
            begin
                int budget = 0;
                logic [40:0] got;
                tick();
                got = small_out(n);
                while (!got[40] && budget < 60) begin
                    tick();
                    got = small_out(n);
                    budget++;
                end
                if (got[40] !== 1'b1) begin
                    cmp++; mism++;
                    $display("FAIL sweep_n%0d start: data_out_en never rose", n);
                end else begin
                    first_out = cyc;
                    for (int k = 0; k < n; k++) begin
                        logic [40:0] exp;
                        if (k > 0) tick();
                        exp = {1'b1, 6'(k), k == 0, k == n - 1, 16'(k), 16'(bitrev(k, bits))};
                        got = small_out(n);
                        cmp++;
                        if (got !== exp) begin
                            mism++;
                            $display("FAIL sweep_n%0d bin %0d: got %h expected %h", n, k, got, exp);
                        end
                    end
                end
            end
        join
        if (first_out >= 0) begin
            cmp++;
            if (first_out !== last + 2) begin
                mism++;
                $display("FAIL sweep_n%0d latency: bin0 at edge %0d expected %0d", n, first_out, last + 2);
            end
        end
    endtask

    task automatic test_param_sweep();
        run_small(16);
        run_small(4);
    endtask

    initial begin
        reset = 1'b0;
        in_en = 1'b0; in_real = '0; in_imag = '0;
        s16_in_en = 1'b0; s16_in_real = '0; s16_in_imag = '0;
        s4_in_en = 1'b0; s4_in_real = '0; s4_in_imag = '0;
        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_mid_frame_reset();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
